arduino_cell_receiver: RTL and testbench
========================================

# arduino_cell_receiver

Receives the Arduino's parallel maze-update bus (3 data bits, 1 strobe, 5 address bits) asynchronously and assembles three 3-bit beats into one 9-bit maze cell word. It sits directly upstream of the VGA cell RAM and its renderer. It resynchronises the bus into the 25 MHz video clock, frames transfers on the sync address, and checks address consistency and inter-beat timeout. Each completed cell is issued as a single one-cycle write strobe with address and data.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flop depth of the input synchroniser (≥2).
- NUM_CELLS, 20: valid cell addresses are 0..NUM_CELLS-1.
- SYNC_ADDR, 31: address value marking a frame-sync beat.
- TIMEOUT, 25000: CLOCK cycles (1 ms) allowed between beats inside a frame.

Ports:
- CLOCK  in  1  25 MHz video clock; the single clock of the block.
- RESET  in  1  synchronous, active-high reset.
- ard_data  in  3  async Arduino data bits.
- ard_strobe  in  1  async Arduino beat strobe; a beat is its rising edge.
- ard_addr  in  5  async Arduino cell address.
- wr_en  out  1  one-cycle cell-RAM write strobe.
- wr_addr  out  5  cell address, valid while wr_en is high.
- wr_data  out  9  cell word, valid while wr_en is high. Fields: [8:6] status, [5:2] walls S/E/N/W, [1:0] treasure.
- frame_err  out  1  one-cycle pulse on each aborted frame.
- err_count  out  8  count of aborted frames, saturating at 255.
- busy  out  1  high while a frame is in progress (state ≠ HUNT).

## Operation
- All 9 input bits pass through SYNC_STAGES flops. A beat is detected when the last strobe stage is 1 and a further delayed copy is 0.
- Data and address are taken from the last sync stage in the same cycle as the detected strobe edge. The Arduino holds data and address stable for ≥2 µs around the strobe edge.
- States:
  - HUNT: a beat with addr=SYNC_ADDR → B0. Any other beat is ignored, with no error.
  - B0: a valid address (<NUM_CELLS) latches the address and stores data into bits [2:0] → B1. An invalid address (not SYNC_ADDR and ≥NUM_CELLS) → error, HUNT.
  - B1: the address must equal the latched address; data goes to [5:3] → B2.
  - B2: the address must match; data goes to [8:6]; write issued → HUNT.
- Any address mismatch in B1 or B2 → error, HUNT.
- A sync beat in B0 → B0 with no error. A sync beat in B1 or B2 → error, then B0. The restart wins.
- Timeout counter: cleared on every beat, counts in B0/B1/B2. On reaching TIMEOUT it returns the FSM to HUNT; this is an error only from B1 or B2.
- Error action: frame_err pulses for one cycle, err_count increments unless already 255, and the partial word is discarded with no write.
- A write is issued only after three consistent beats. A frame yields exactly one write.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, frame_err=0, err_count=0, busy=0, FSM=HUNT, sync flops=0, timeout counter=0.
- If ard_strobe is first sampled high at edge n, the beat is accepted at edge n+SYNC_STAGES.
- For a third beat, wr_en, wr_addr and wr_data are registered at edge n+SYNC_STAGES+1. wr_en stays high for exactly 1 cycle; wr_addr and wr_data hold until the next write.
- frame_err is registered at the edge following the error-causing beat or the timeout expiry.
- Minimum beat spacing is 2·(SYNC_STAGES+1) CLOCK cycles; faster strobes are out of contract.
- A timeout and a beat in the same cycle: the beat wins and the counter clears.
- RESET mid-frame: abort silently with no frame_err; err_count is cleared; any pending wr_en is suppressed.

## Structure
- Shared package maze_pkg holds: SYNC_ADDR, NUM_CELLS, the cell field positions (STATUS_MSB/LSB, WALL_S/E/N/W, TREASURE_MSB/LSB), the FSM state encoding {HUNT, B0, B1, B2}, and the status and treasure code constants used by the renderer.
- One sub-module, bus_synchronizer, parameterised by width and depth, instantiated once for the 9 input bits. The FSM, timeout counter and error counter stay in arduino_cell_receiver.

## Test plan
- Sync beat, then beats addr=7 with data 3'b101, 3'b100, 3'b110 → exactly one wr_en, wr_addr=7, wr_data=9'b110_100_101, frame_err never high.
- Sync beat, then addr 3, 3, 4 → no wr_en, one frame_err pulse, err_count=1, busy=0 afterwards.
- Sync beat, addr 5 beat, then sync beat, then 3 beats at addr 9 → err_count=1, single write to addr 9 with the second frame's data only.
- Sync beat, two beats at addr 2, then no strobe for 25000 cycles → frame_err at expiry, no write, next sync frame writes normally.
- Sync beat, then addr 20 → frame_err, no write. Separately, 300 bad frames → err_count saturates at 255.
- RESET asserted between beat 2 and beat 3 → no write, no frame_err, err_count=0, busy=0. A subsequent stray beat 3 is ignored.

Source files
------------

// File: rtl/maze_pkg.sv
// maze_pkg
//   Shared definitions for the maze cell path: bus geometry, cell word field
//   positions, receiver FSM state encoding, and the status / treasure codes
//   that the VGA renderer decodes from a cell word.
//   No ports; imported by arduino_cell_receiver and the renderer side.
package maze_pkg;

    // Arduino bus geometry
    localparam int DATA_W = 3;
    localparam int ADDR_W = 5;
    localparam int CELL_W = 9;

    // Address space of the maze
    localparam int NUM_CELLS = 20;
    localparam int SYNC_ADDR = 31;

    // Cell word field positions
    localparam int STATUS_MSB   = 8;
    localparam int STATUS_LSB   = 6;
    localparam int WALL_S       = 5;
    localparam int WALL_E       = 4;
    localparam int WALL_N       = 3;
    localparam int WALL_W       = 2;
    localparam int TREASURE_MSB = 1;
    localparam int TREASURE_LSB = 0;

    // Receiver FSM states
    typedef enum logic [1:0] {
        HUNT = 2'd0,
        B0   = 2'd1,
        B1   = 2'd2,
        B2   = 2'd3
    } rx_state_t;

    // Status codes carried in [8:6]
    localparam logic [2:0] STATUS_UNKNOWN   = 3'd0;
    localparam logic [2:0] STATUS_VISITED   = 3'd1;
    localparam logic [2:0] STATUS_CURRENT   = 3'd2;
    localparam logic [2:0] STATUS_FRONTIER  = 3'd3;
    localparam logic [2:0] STATUS_DONE      = 3'd4;

    // Treasure codes carried in [1:0]
    localparam logic [1:0] TREASURE_NONE   = 2'd0;
    localparam logic [1:0] TREASURE_RED    = 2'd1;
    localparam logic [1:0] TREASURE_GREEN  = 2'd2;
    localparam logic [1:0] TREASURE_BLUE   = 2'd3;

endpackage

// File: rtl/bus_synchronizer.sv
// bus_synchronizer
//   Multi-flop synchroniser for a bus of independent asynchronous bits.
//   Every bit passes through DEPTH flops; the last stage drives dout.
// Ports:
//   clk    in          sampling clock
//   reset  in          synchronous active-high reset, clears all stages
//   din    in  WIDTH   asynchronous input bits
//   dout   out WIDTH   synchronised bits (last stage)
module bus_synchronizer #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stages;

    always_ff @(posedge clk) begin
        if (reset) begin
            stages <= '0;
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/arduino_cell_receiver.sv
// arduino_cell_receiver
//   Receives the Arduino's asynchronous maze-update bus, resynchronises it
//   into the video clock, frames transfers on a sync beat and assembles three
//   3-bit beats at a consistent address into one 9-bit cell word, issued as a
//   single one-cycle write to the cell RAM. Inconsistent or timed-out frames
//   are discarded and counted.
// Ports:
//   CLOCK      in   1  video clock
//   RESET      in   1  synchronous active-high reset
//   ard_data   in   3  async data bits
//   ard_strobe in   1  async beat strobe (beat = rising edge)
//   ard_addr   in   5  async cell address
//   wr_en      out  1  one-cycle cell-RAM write strobe
//   wr_addr    out  5  cell address, held until the next write
//   wr_data    out  9  cell word, held until the next write
//   frame_err  out  1  one-cycle pulse per aborted frame
//   err_count  out  8  aborted-frame count, saturating at 255
//   busy       out  1  frame in progress
//
// Handshake: there is no back-pressure. wr_en is a valid-only strobe; the
// cell RAM must accept wr_addr/wr_data in the single cycle wr_en is high.
module arduino_cell_receiver
    import maze_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_CELLS   = maze_pkg::NUM_CELLS,
    parameter int SYNC_ADDR   = maze_pkg::SYNC_ADDR,
    parameter int TIMEOUT     = 25000
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] ard_data,
    input  logic              ard_strobe,
    input  logic [ADDR_W-1:0] ard_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [CELL_W-1:0] wr_data,
    output logic              frame_err,
    output logic [7:0]        err_count,
    output logic              busy
);

    localparam int BUS_W = 1 + ADDR_W + DATA_W;
    localparam int TW    = $clog2(TIMEOUT + 1);

    // Synchronised bus: {strobe, addr, data}
    logic [BUS_W-1:0]  bus_raw;
    logic [BUS_W-1:0]  bus_sync;
    logic              strobe_s;
    logic              strobe_d;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] data_s;
    logic              beat;

    assign bus_raw = {ard_strobe, ard_addr, ard_data};

    bus_synchronizer #(
        .WIDTH (BUS_W),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk   (CLOCK),
        .reset (RESET),
        .din   (bus_raw),
        .dout  (bus_sync)
    );

    assign strobe_s = bus_sync[BUS_W-1];
    assign addr_s   = bus_sync[DATA_W +: ADDR_W];
    assign data_s   = bus_sync[DATA_W-1:0];
    assign beat     = strobe_s & ~strobe_d;

    // FSM and frame registers
    rx_state_t         state, state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [CELL_W-1:0] word_q;
    logic [TW-1:0]     tmo_cnt;
    logic              wr_go;

    logic is_sync;
    logic addr_valid;
    logic addr_match;
    logic tmo_hit;
    logic err;
    logic ld0, ld1, ld2;

    assign is_sync    = (addr_s == ADDR_W'(SYNC_ADDR));
    assign addr_valid = (int'(addr_s) < NUM_CELLS);
    assign addr_match = (addr_s == addr_q);
    // Expires TIMEOUT cycles after the last accepted beat
    assign tmo_hit    = (state != HUNT) && (tmo_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        state_next = state;
        err        = 1'b0;
        ld0        = 1'b0;
        ld1        = 1'b0;
        ld2        = 1'b0;
        if (beat) begin
            // A beat always takes priority over a coincident timeout
            unique case (state)
                HUNT: begin
                    if (is_sync) state_next = B0;
                end
                B0: begin
                    if (is_sync) begin
                        state_next = B0;
                    end else if (addr_valid) begin
                        state_next = B1;
                        ld0        = 1'b1;
                    end else begin
                        state_next = HUNT;
                        err        = 1'b1;
                    end
                end
                B1, B2: begin
                    if (is_sync) begin
                        // Restart: abort the partial frame, begin a new one
                        state_next = B0;
                        err        = 1'b1;
                    end else if (addr_match) begin
                        state_next = (state == B1) ? B2 : HUNT;
                        ld1        = (state == B1);
                        ld2        = (state == B2);
                    end else begin
                        state_next = HUNT;
                        err        = 1'b1;
                    end
                end
                default: state_next = HUNT;
            endcase
        end else if (tmo_hit) begin
            state_next = HUNT;
            // Waiting for the first data beat after sync is not an error
            err        = (state == B1) || (state == B2);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state     <= HUNT;
            strobe_d  <= 1'b0;
            addr_q    <= '0;
            word_q    <= '0;
            tmo_cnt   <= '0;
            wr_go     <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            state    <= state_next;
            strobe_d <= strobe_s;

            if (beat || state == HUNT) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            if (ld0) begin
                addr_q      <= addr_s;
                word_q      <= '0;
                word_q[2:0] <= data_s;
            end
            if (ld1) word_q[5:3] <= data_s;
            if (ld2) word_q[8:6] <= data_s;

            // Write goes out one cycle after the third beat is stored
            wr_go <= ld2;
            wr_en <= wr_go;
            if (wr_go) begin
                wr_addr <= addr_q;
                wr_data <= word_q;
            end

            frame_err <= err;
            if (err && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    assign busy = (state != HUNT);

endmodule

// File: tb/tb_arduino_cell_receiver.sv
// Self-checking bench for arduino_cell_receiver.
module tb_arduino_cell_receiver;
    import maze_pkg::*;

    // ---------------- clock / reset ----------------
    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic [2:0] ard_data = '0;
    logic       ard_strobe = 1'b0;
    logic [4:0] ard_addr = '0;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [8:0] wr_data;
    logic       frame_err;
    logic [7:0] err_count;
    logic       busy;

    always #20 CLOCK = ~CLOCK;

    arduino_cell_receiver dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .ard_data   (ard_data),
        .ard_strobe (ard_strobe),
        .ard_addr   (ard_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_err  (frame_err),
        .err_count  (err_count),
        .busy       (busy)
    );

    // ---------------- scoreboard state ----------------
    logic [13:0] exp_q[$];   // {addr, word} of expected writes
    logic [7:0]  err_q[$];   // expected err_count value at each frame_err
    int          n_checks = 0;
    int          n_fail   = 0;
    int          model_err = 0;
    logic [13:0] w_exp;
    logic [7:0]  e_exp;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge CLOCK) begin
        if (!RESET) begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr=%0d data=%b expected no write",
                             wr_addr, wr_data);
                end else begin
                    w_exp = exp_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(w_exp[13:9]));
                    check("wr_data", 32'(wr_data), 32'(w_exp[8:0]));
                end
            end
            if (frame_err) begin
                if (err_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame_err: got pulse (err_count=%0d) expected none",
                             err_count);
                end else begin
                    e_exp = err_q.pop_front();
                    check("err_count_at_pulse", 32'(err_count), 32'(e_exp));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge CLOCK);
        RESET = 1'b1;
        ard_strobe = 1'b0;
        repeat (3) @(negedge CLOCK);
        RESET = 1'b0;
        model_err = 0;
        @(negedge CLOCK);
    endtask

    task automatic send_beat(input logic [4:0] a, input logic [2:0] d);
        @(negedge CLOCK);
        ard_addr = a;
        ard_data = d;
        repeat (2) @(negedge CLOCK);
        ard_strobe = 1'b1;
        repeat (4) @(negedge CLOCK);
        ard_strobe = 1'b0;
        repeat (3) @(negedge CLOCK);
    endtask

    task automatic send_sync();
        send_beat(5'd31, 3'd0);
    endtask

    task automatic expect_write(input logic [4:0] a, input logic [8:0] w);
        exp_q.push_back({a, w});
    endtask

    task automatic expect_err();
        if (model_err < 255) model_err++;
        err_q.push_back(8'(model_err));
    endtask

    task automatic good_frame(input logic [4:0] a, input logic [2:0] d0,
                              input logic [2:0] d1, input logic [2:0] d2);
        expect_write(a, {d2, d1, d0});
        send_sync();
        send_beat(a, d0);
        send_beat(a, d1);
        send_beat(a, d2);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        repeat (3) @(negedge CLOCK);
        RESET = 1'b0;
        @(negedge CLOCK);
        check("reset_wr_en",     32'(wr_en),     32'd0);
        check("reset_wr_addr",   32'(wr_addr),   32'd0);
        check("reset_wr_data",   32'(wr_data),   32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_err_count", 32'(err_count), 32'd0);
        check("reset_busy",      32'(busy),      32'd0);

        // Basic frame: 110_100_101 at addr 7
        good_frame(5'd7, 3'b101, 3'b100, 3'b110);
        check("t1_err_count", 32'(err_count), 32'd0);
        check("t1_busy",      32'(busy),      32'd0);

        // Boundary addresses
        good_frame(5'd19, 3'b111, 3'b000, 3'b011);
        good_frame(5'd0,  3'b010, 3'b001, 3'b100);

        // Stray beat in HUNT ignored
        send_beat(5'd4, 3'b111);
        check("stray_busy", 32'(busy), 32'd0);

        // Address mismatch on third beat
        do_reset();
        send_sync();
        send_beat(5'd3, 3'b001);
        send_beat(5'd3, 3'b010);
        expect_err();
        send_beat(5'd4, 3'b011);
        check("t2_err_count", 32'(err_count), 32'd1);
        check("t2_busy",      32'(busy),      32'd0);

        // Sync restart mid-frame: second frame's data only
        do_reset();
        send_sync();
        send_beat(5'd5, 3'b111);
        expect_err();
        send_sync();
        check("t3_busy_after_restart", 32'(busy), 32'd1);
        send_beat(5'd9, 3'b011);
        send_beat(5'd9, 3'b110);
        expect_write(5'd9, {3'b001, 3'b110, 3'b011});
        send_beat(5'd9, 3'b001);
        check("t3_err_count", 32'(err_count), 32'd1);

        // Repeated sync in B0 is not an error
        do_reset();
        send_sync();
        send_sync();
        check("sync_in_b0_err_count", 32'(err_count), 32'd0);
        good_frame(5'd12, 3'b110, 3'b101, 3'b010);

        // Inter-beat timeout from B2
        do_reset();
        send_sync();
        send_beat(5'd2, 3'b001);
        send_beat(5'd2, 3'b010);
        check("t4_busy_before", 32'(busy), 32'd1);
        expect_err();
        repeat (25020) @(negedge CLOCK);
        check("t4_busy_after",  32'(busy),      32'd0);
        check("t4_err_count",   32'(err_count), 32'd1);
        good_frame(5'd2, 3'b100, 3'b010, 3'b001);

        // Invalid address, then saturation
        do_reset();
        send_sync();
        expect_err();
        send_beat(5'd20, 3'b000);
        check("t5_err_count", 32'(err_count), 32'd1);
        check("t5_busy",      32'(busy),      32'd0);
        for (int i = 0; i < 300; i++) begin
            send_sync();
            expect_err();
            send_beat(5'd20, 3'b000);
        end
        check("t5_saturated", 32'(err_count), 32'd255);

        // Reset between beat 2 and beat 3
        do_reset();
        send_sync();
        send_beat(5'd7, 3'b101);
        send_beat(5'd7, 3'b100);
        do_reset();
        check("t6_err_count", 32'(err_count), 32'd0);
        check("t6_busy",      32'(busy),      32'd0);
        check("t6_wr_en",     32'(wr_en),     32'd0);
        send_beat(5'd7, 3'b110);
        check("t6_busy_after_stray", 32'(busy), 32'd0);

        repeat (10) @(negedge CLOCK);
        check("writes_outstanding", 32'(exp_q.size()), 32'd0);
        check("errors_outstanding", 32'(err_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
